// File: rtl/rto_fifo_reader.sv
// Timed consumer on the RTO FIFO read side: holds each {timestamp, data} entry until the
// global counter reaches its timestamp, then pulses it out. Late-entry policy: RTO_LATE_DROP_EN.
module rto_fifo_reader #(
    parameter int TS_WIDTH   = 64,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [TS_WIDTH-1:0]            counter,
    input  logic                           enable,
    input  logic                           flush,
    input  logic                           clear_error,
    input  logic [TS_WIDTH+DATA_WIDTH-1:0] fifo_dout,
    input  logic                           fifo_empty,
    output logic                           fifo_rd_en,
    output logic [DATA_WIDTH-1:0]          dout,
    output logic                           dout_valid,
    output logic                           late_error,
    output logic [CNT_WIDTH-1:0]           late_count,
    output logic                           busy
);

    // Handshake: fifo_rd_en is a request strobe; the FIFO returns the entry on fifo_dout
    // exactly one cycle later, with no back-pressure. dout is qualified by dout_valid only.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [TS_WIDTH-1:0]     ts_q, ts_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic                    late_error_q, late_error_d;
    logic [CNT_WIDTH-1:0]    late_count_q, late_count_d;
    logic                    rd_en;
    logic                    release_now;
    logic                    late_event;

    always_comb begin
        state_d      = state_q;
        ts_d         = ts_q;
        data_d       = data_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        late_error_d = late_error_q;
        late_count_d = late_count_q;
        rd_en        = 1'b0;
        release_now  = 1'b0;
        late_event   = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    // Drain mode: keep popping, returned data is never captured.
                    rd_en = !fifo_empty;
                end else if (enable && !fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    ts_d    = fifo_dout[TS_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
                    data_d  = fifo_dout[DATA_WIDTH-1:0];
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (counter >= ts_q) begin
                    late_event = (counter != ts_q);
`ifdef RTO_LATE_DROP_EN
                    release_now = !late_event;
`else
                    release_now = 1'b1;
`endif
                    // Chain straight into the next read so consecutive entries take 2 cycles.
                    if (enable && !fifo_empty) begin
                        rd_en   = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (release_now) begin
            dout_d       = data_q;
            dout_valid_d = 1'b1;
        end

        if (clear_error) begin
            late_error_d = 1'b0;
            late_count_d = '0;
        end else if (late_event) begin
            late_error_d = 1'b1;
            if (late_count_q != {CNT_WIDTH{1'b1}}) begin
                late_count_d = late_count_q + 1'b1;
            end
        end

        if (rst) begin
            rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ts_q         <= '0;
            data_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            late_error_q <= 1'b0;
            late_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            data_q       <= data_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            late_error_q <= late_error_d;
            late_count_q <= late_count_d;
        end
    end

    assign fifo_rd_en = rd_en;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign late_error = late_error_q;
    assign late_count = late_count_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rto_fifo_reader.sv
// Bench for rto_fifo_reader: behavioural FIFO, free-running counter, release-time model,
// expected-pulse queue popped by an independent monitor.
module tb_rto_fifo_reader;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   counter = '0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          clear_error = 1'b0;
  logic [127:0]  fifo_dout = '0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [63:0]   dout;
  logic          dout_valid;
  logic          late_error;
  logic [31:0]   late_count;
  logic          busy;

  int checks = 0;
  int failures = 0;

  // expected pulses: {counter value while dout_valid is high, data}
  logic [127:0] exp_q[$];

  logic [127:0]  mem[0:63];
  int unsigned   wr_ptr = 0;
  int unsigned   rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  int unsigned model_cnt = 0;
  logic        model_err = 1'b0;
  logic [63:0] burst_ts[8];
  logic [63:0] burst_data[8];

  rto_fifo_reader dut (
    .clk(clk), .rst(rst), .counter(counter), .enable(enable), .flush(flush),
    .clear_error(clear_error), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .dout(dout), .dout_valid(dout_valid),
    .late_error(late_error), .late_count(late_count), .busy(busy)
  );

  // clock / time base / FIFO read port
  always #5 clk = ~clk;

  always @(posedge clk) counter <= counter + 64'd1;

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] ts, input logic [63:0] data);
    mem[wr_ptr[5:0]] = {ts, data};
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || !fifo_empty) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout busy=%0b fifo_empty=%0b required=0/1", busy, fifo_empty);
    end
  endtask

  task automatic check_late();
    check("late_count", late_count, model_cnt);
    check("late_error", late_error, model_err);
  endtask

  // Queue n entries, start reading, and predict each release from the timing rules:
  // an entry is compared from 2 cycles after its read; it releases at max(ts, that cycle).
  task automatic run_burst(input int n);
    logic [63:0] hs;
    logic [63:0] rel;
    logic        late;
    wait_idle();
    for (int k = 0; k < n; k++) push(burst_ts[k], burst_data[k]);
    @(negedge clk);
    enable = 1'b1;
    hs = counter + 64'd2;
    for (int k = 0; k < n; k++) begin
      late = (burst_ts[k] < hs);
      rel  = late ? hs : burst_ts[k];
      if (late) begin
        model_cnt++;
        model_err = 1'b1;
      end
`ifdef RTO_LATE_DROP_EN
      if (!late) exp_q.push_back({rel + 64'd1, burst_data[k]});
`else
      exp_q.push_back({rel + 64'd1, burst_data[k]});
`endif
      hs = rel + 64'd2;
    end
    wait_idle();
    enable = 1'b0;
    check_late();
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    model_cnt = 0;
    model_err = 1'b0;
    check_late();
  endtask

  // monitor: samples 2 time units after the active edge
  logic [63:0] last_dout = '0;
  always begin
    logic [127:0] e;
    @(posedge clk);
    #2;
    if (rst) begin
      last_dout = '0;
    end else if (dout_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse dout=%0h counter=%0d required=no_pulse", dout, counter);
      end else begin
        e = exp_q.pop_front();
        check("pulse_data", {64'd0, dout}, {64'd0, e[63:0]});
        check("pulse_time", {64'd0, counter}, {64'd0, e[127:64]});
        last_dout = e[63:0];
      end
    end else begin
      check("dout_hold", {64'd0, dout}, {64'd0, last_dout});
    end
  end

  initial begin
    logic [63:0] base;
    int n;

    repeat (3) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check_late();
    rst = 1'b0;

    // single on-time entry
    burst_ts[0] = 64'd100; burst_data[0] = 64'hA5;
    run_burst(1);

    // two spaced entries
    base = counter + 64'd200;
    burst_ts[0] = base;          burst_data[0] = 64'h1;
    burst_ts[1] = base + 64'd10; burst_data[1] = 64'h2;
    run_burst(2);
    check("busy_after_pair", busy, 0);

    // stale entry
    burst_ts[0] = counter - 64'd30; burst_data[0] = 64'hDEAD_BEEF;
    run_burst(1);

    // timestamps one apart: second is late
    base = counter + 64'd20;
    burst_ts[0] = base;         burst_data[0] = 64'h300;
    burst_ts[1] = base + 64'd1; burst_data[1] = 64'h301;
    run_burst(2);
    pulse_clear();

    // flush while holding, with two more entries queued
    wait_idle();
    base = counter + 64'd100;
    for (int k = 0; k < 3; k++) push(base + k, 64'h500 + k);
    @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_before_flush", busy, 1);
    flush = 1'b1;
    repeat (4) @(negedge clk);
    flush = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("flush_drained", fifo_empty, 1);
    check("flush_idle", busy, 0);
    check_late();

    // randomized bursts
    for (int b = 0; b < 24; b++) begin
      n = $urandom_range(1, 5);
      base = counter + $urandom_range(0, 12);
      for (int k = 0; k < n; k++) begin
        burst_ts[k]   = base;
        burst_data[k] = {$urandom, $urandom};
        base = base + $urandom_range(0, 6);
      end
      run_burst(n);
      if ($urandom_range(0, 3) == 0) pulse_clear();
    end

    // make sure the late flag is set before the reset test
    burst_ts[0] = counter - 64'd5; burst_data[0] = 64'h77;
    run_burst(1);

    // reset while holding; a second entry stays queued
    wait_idle();
    base = counter + 64'd30;
    push(base, 64'h1000);
    push(base + 64'd1, 64'h1001);
    @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_before_rst", busy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_rd_en", fifo_rd_en, 0);
    check("rst_mid_dout", dout, 0);
    check("rst_mid_dout_valid", dout_valid, 0);
    check("rst_mid_busy", busy, 0);
    model_cnt = 0;
    model_err = 1'b0;
    check_late();
    enable = 1'b0;
    flush = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b0;
    check("rst_drained", fifo_empty, 1);
    repeat (45) @(negedge clk);
    check("rst_no_release_busy", busy, 0);

    repeat (5) @(negedge clk);
    check("pending_pulses", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
